// File: rtl/if_dual_pkg.sv
// if_dual_pkg: shared types and the bundle-splitting helper for the dual-issue fetch stage.
package if_dual_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr1;
      logic [31:0] instr2;
   } fetch_pair_t;

   typedef struct packed {
      logic [31:0] pc;
      logic        slot;
   } fetch_tag_t;

   // A fetch starting on the odd word (slot 1) only uses the upper half of the bundle.
   function automatic fetch_pair_t split_bundle(input fetch_tag_t tag, input logic [63:0] data);
      fetch_pair_t pair;
      pair.pc = tag.pc;
      if (tag.slot) begin
         pair.instr1 = data[63:32];
         pair.instr2 = NOP_INSTR;
      end else begin
         pair.instr1 = data[31:0];
         pair.instr2 = data[63:32];
      end
      return pair;
   endfunction

endpackage

// File: rtl/if_dual_fifo.sv
// if_dual_fifo: DEPTH-entry synchronous FIFO with flush and occupancy count; used for tags and pairs.
module if_dual_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_flush,
   input  logic                   i_push,
   input  logic [WIDTH-1:0]       i_data,
   input  logic                   i_pop,
   output logic [WIDTH-1:0]       o_data,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_data  = r_mem[r_rd_ptr];

   // A push into a full FIFO is accepted only when the head leaves in the same cycle.
   assign w_pop  = i_pop & ~o_empty;
   assign w_push = i_push & (~o_full | w_pop);

   // NOTE: sequential state is written with <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // NOTE: storage is not reset; entries are only read once the count says they were written.
   always_ff @(posedge clk) begin
      if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
   end

   no_overflow: assert property (@(posedge clk) disable iff (reset)
      !(i_push && o_full && !i_pop && !i_flush));

endmodule

// File: rtl/if_dual_fetch.sv
// if_dual_fetch: dual-issue fetch stage feeding decode with {pc, instr1, instr2} pairs.
// Define IF_DUAL_BYPASS_EN to let a response reach the outputs in its arrival cycle when the queue is empty.
module if_dual_fetch
   import if_dual_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [63:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr1,
   output logic [31:0] out_instr2
);
   localparam int            CW      = $clog2(DEPTH) + 1;
   localparam logic [CW:0]   CREDITS = (CW + 1)'(DEPTH);

   logic [31:0]   r_fetch_pc;
   logic [CW-1:0] r_drop;

   fetch_tag_t    w_tag_in;
   fetch_tag_t    w_tag_head;
   logic [CW-1:0] w_outstanding;
   logic          w_tag_full;
   logic          w_tag_empty;
   fetch_pair_t   w_rsp_pair;
   fetch_pair_t   w_q_head;
   fetch_pair_t   w_head;
   logic [CW-1:0] w_q_count;
   logic          w_q_full;
   logic          w_q_empty;
   logic [CW:0]   w_credit_used;
   logic          w_req_fire;
   logic          w_rsp_fire;
   logic          w_rsp_live;
   logic          w_bypass;
   logic          w_q_push;
   logic          w_q_pop;

   // Every request either ends up in the queue or is dropped, so this sum bounds queue occupancy.
   assign w_credit_used  = {1'b0, w_q_count} + {1'b0, w_outstanding};
   assign imem_req_valid = ~reset & ~redirect_valid & ~w_tag_full & ~w_q_full
                         & (w_credit_used < CREDITS);
   assign imem_req_addr  = {r_fetch_pc[31:3], 3'b000};
   assign w_req_fire     = imem_req_valid & imem_req_ready;
   assign w_tag_in       = '{pc: r_fetch_pc, slot: r_fetch_pc[2]};

   assign w_rsp_fire = imem_rsp_valid & ~w_tag_empty;
   assign w_rsp_pair = split_bundle(w_tag_head, imem_rsp_data);
   assign w_rsp_live = w_rsp_fire & (r_drop == '0) & ~redirect_valid;

`ifdef IF_DUAL_BYPASS_EN
   assign w_bypass = w_rsp_live & w_q_empty;
`else
   assign w_bypass = 1'b0;
`endif

   assign out_valid  = ~w_q_empty | w_bypass;
   assign w_head     = !w_q_empty ? w_q_head : (w_bypass ? w_rsp_pair : '0);
   assign out_pc     = w_head.pc;
   assign out_instr1 = w_head.instr1;
   assign out_instr2 = w_head.instr2;
   assign w_q_pop    = ~w_q_empty & out_ready;
   assign w_q_push   = w_rsp_live & ~(w_bypass & out_ready);

   if_dual_fifo #(.WIDTH($bits(fetch_tag_t)), .DEPTH(DEPTH)) u_tag_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_flush (1'b0),
      .i_push  (w_req_fire),
      .i_data  (w_tag_in),
      .i_pop   (w_rsp_fire),
      .o_data  (w_tag_head),
      .o_full  (w_tag_full),
      .o_empty (w_tag_empty),
      .o_count (w_outstanding)
   );

   if_dual_fifo #(.WIDTH($bits(fetch_pair_t)), .DEPTH(DEPTH)) u_pair_q (
      .clk     (clk),
      .reset   (reset),
      .i_flush (redirect_valid),
      .i_push  (w_q_push),
      .i_data  (w_rsp_pair),
      .i_pop   (w_q_pop),
      .o_data  (w_q_head),
      .o_full  (w_q_full),
      .o_empty (w_q_empty),
      .o_count (w_q_count)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_fetch_pc <= RESET_PC;
         r_drop     <= '0;
      end else if (redirect_valid) begin
         r_fetch_pc <= redirect_pc;
         // Everything still in flight after this cycle, dropped or not, belongs to the old path.
         r_drop     <= w_outstanding - CW'(w_rsp_fire);
      end else begin
         if (w_req_fire) r_fetch_pc <= r_fetch_pc + (r_fetch_pc[2] ? 32'd4 : 32'd8);
         if (w_rsp_fire && r_drop != '0) r_drop <= r_drop - CW'(1);
      end
   end

endmodule

// File: tb/tb_if_dual_fetch.sv
// tb_if_dual_fetch: randomized bench comparing if_dual_fetch against a queue-level fetch model.
module tb_if_dual_fetch;
   import if_dual_pkg::*;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [63:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr1;
   logic [31:0] out_instr2;

   always #5 clk = ~clk;

   if_dual_fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_instr1     (out_instr1),
      .out_instr2     (out_instr2)
   );

   typedef struct { logic [31:0] pc; bit stale; } flight_t;
   typedef struct { logic [31:0] addr; int due; } mreq_t;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // Model: fetched-but-unanswered requests, pairs waiting for decode, next fetch pc.
   flight_t     flight[$];
   fetch_pair_t exp_q[$];
   logic [31:0] m_pc;

   // Memory side and observation logs.
   mreq_t       mem_q[$];
   logic [31:0] req_log[$];
   fetch_pair_t out_log[$];

   bit          d_reset, d_out_ready, d_req_ready, d_redirect, redir_on_rsp, rsp_gaps;
   logic [31:0] d_redirect_pc;
   int          mem_lat;

   function automatic logic [31:0] word(input logic [31:0] a);
      return a * 32'h9E37_79B1 + 32'h1234_5678;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic reset_model();
      check("rst_req_valid", imem_req_valid, 1'b0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_pc", out_pc, 32'h0);
      check("rst_out_instr1", out_instr1, 32'h0);
      check("rst_out_instr2", out_instr2, 32'h0);
      m_pc = RESET_PC;
      flight.delete();
      exp_q.delete();
      mem_q.delete();
   endtask

   task automatic compare_and_update();
      bit          exp_rv, live, bypass, exp_ov;
      fetch_pair_t rsp_pair, head;
      flight_t     f;
      int          lat;

      exp_rv = !redirect_valid && (exp_q.size() + flight.size() < DEPTH);
      check("req_valid", imem_req_valid, exp_rv);
      if (exp_rv) check("req_addr", imem_req_addr, {m_pc[31:3], 3'b000});

      live     = 1'b0;
      rsp_pair = '0;
      if (imem_rsp_valid) begin
         if (flight.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_without_request: got response with no modelled request (cycle %0d)", cyc);
         end else begin
            f               = flight.pop_front();
            live            = !f.stale && !redirect_valid;
            rsp_pair.pc     = f.pc;
            rsp_pair.instr1 = word(f.pc);
            rsp_pair.instr2 = f.pc[2] ? 32'h0 : word(f.pc + 32'd4);
         end
      end

`ifdef IF_DUAL_BYPASS_EN
      bypass = live && exp_q.size() == 0;
`else
      bypass = 1'b0;
`endif
      exp_ov = exp_q.size() > 0 || bypass;
      head   = exp_q.size() > 0 ? exp_q[0] : (bypass ? rsp_pair : '0);
      check("out_valid", out_valid, exp_ov);
      check("out_pc", out_pc, head.pc);
      check("out_instr1", out_instr1, head.instr1);
      check("out_instr2", out_instr2, head.instr2);

      if (out_valid && out_ready)
         out_log.push_back('{pc: out_pc, instr1: out_instr1, instr2: out_instr2});
      if (exp_ov && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (live && !(bypass && out_ready)) exp_q.push_back(rsp_pair);

      if (redirect_valid) begin
         exp_q.delete();
         foreach (flight[i]) flight[i].stale = 1'b1;
         m_pc = redirect_pc;
      end else if (exp_rv && imem_req_ready) begin
         flight.push_back('{pc: m_pc, stale: 1'b0});
         m_pc = m_pc + (m_pc[2] ? 32'd4 : 32'd8);
      end

      // The memory answers whatever address the DUT actually put on the bus.
      if (imem_rsp_valid) void'(mem_q.pop_front());
      if (imem_req_valid && imem_req_ready) begin
         lat = (mem_lat == 0) ? $urandom_range(4, 1) : mem_lat;
         mem_q.push_back('{addr: imem_req_addr, due: cyc + lat});
         req_log.push_back(imem_req_addr);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      reset          = d_reset;
      out_ready      = d_out_ready;
      imem_req_ready = d_req_ready;
      redirect_valid = d_redirect;
      redirect_pc    = d_redirect_pc;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = {$urandom, $urandom};
      if (!d_reset && mem_q.size() > 0 && mem_q[0].due <= cyc &&
          !(rsp_gaps && $urandom_range(3) == 0)) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = {word(mem_q[0].addr + 32'd4), word(mem_q[0].addr)};
      end
      if (redir_on_rsp && imem_rsp_valid) begin
         redirect_valid = 1'b1;
         redir_on_rsp   = 1'b0;
      end
      @(negedge clk);
      if (d_reset) reset_model();
      else compare_and_update();
      cyc++;
   endtask

   initial begin
      int          n_req, n_out, guard;
      logic [31:0] r;

      reset = 1'b1; out_ready = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
      imem_rsp_data = '0; redirect_valid = 1'b0; redirect_pc = '0;
      d_reset = 1'b1; d_out_ready = 1'b1; d_req_ready = 1'b1; d_redirect = 1'b0;
      d_redirect_pc = '0; redir_on_rsp = 1'b0; rsp_gaps = 1'b0; mem_lat = 1;

      repeat (3) step();
      d_reset = 1'b0;
      repeat (8) step();
      check("start_req0", req_log[0], 32'h0000_0000);
      check("start_req1", req_log[1], 32'h0000_0008);
      check("start_req2", req_log[2], 32'h0000_0010);
      check("start_out_pc", out_log[0].pc, 32'h0000_0000);
      check("start_out_instr1", out_log[0].instr1, 32'h1234_5678);
      check("start_out_instr2", out_log[0].instr2, 32'h8B12_3D3C);

      // Redirect to an odd word: bundle 0x100 yields a single instruction.
      d_redirect = 1'b1; d_redirect_pc = 32'h0000_0104;
      step();
      d_redirect = 1'b0;
      n_req = req_log.size(); n_out = out_log.size();
      repeat (8) step();
      check("redir_req0", req_log[n_req], 32'h0000_0100);
      check("redir_req1", req_log[n_req + 1], 32'h0000_0108);
      check("redir_out_pc", out_log[n_out].pc, 32'h0000_0104);
      check("redir_out_instr1", out_log[n_out].instr1, word(32'h0000_0104));
      check("redir_out_instr2", out_log[n_out].instr2, 32'h0);

      // Backpressure: the queue fills to DEPTH and fetch stops.
      d_out_ready = 1'b0;
      repeat (12) step();
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_req_valid", imem_req_valid, 1'b0);
      d_req_ready = 1'b0; d_out_ready = 1'b1;
      n_out = out_log.size();
      repeat (8) step();
      check("bp_drain_count", out_log.size() - n_out, DEPTH);
      d_req_ready = 1'b1;

      // Slow memory: stale responses in flight across a redirect.
      mem_lat = 3;
      repeat (6) step();
      d_redirect = 1'b1; d_redirect_pc = 32'h0000_2000;
      step();
      d_redirect = 1'b0;
      n_out = out_log.size();
      repeat (15) step();
      check("stale_first_pc", out_log[n_out].pc, 32'h0000_2000);

      // Redirect landing exactly on a response cycle.
      mem_lat = 1; d_redirect_pc = 32'h0000_3004; redir_on_rsp = 1'b1;
      guard = 0;
      while (redir_on_rsp && guard < 20) begin
         step();
         guard++;
      end
      check("redir_on_rsp_hit", redir_on_rsp, 1'b0);
      step();
      check("redir_on_rsp_empty", out_valid, 1'b0);
      repeat (6) step();

      // PC wrap-around.
      d_redirect = 1'b1; d_redirect_pc = 32'hFFFF_FFF8;
      step();
      d_redirect = 1'b0;
      n_req = req_log.size();
      repeat (6) step();
      check("wrap_req0", req_log[n_req], 32'hFFFF_FFF8);
      check("wrap_req1", req_log[n_req + 1], 32'h0000_0000);

      // Randomized traffic.
      rsp_gaps = 1'b1; mem_lat = 0;
      for (int i = 0; i < 3000; i++) begin
         d_out_ready = ($urandom_range(9) < 7);
         d_req_ready = ($urandom_range(3) != 0);
         d_redirect  = ($urandom_range(39) == 0);
         r = $urandom;
         if ($urandom_range(7) == 0) r = 32'hFFFF_FFF0 | (r & 32'h0000_000C);
         d_redirect_pc = {r[31:2], 2'b00};
         step();
      end
      d_redirect = 1'b0; d_out_ready = 1'b1; d_req_ready = 1'b1;
      repeat (20) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
